// File: rtl/uart_alu_sequencer.sv
// Gathers operand A, opcode and operand B from UART bytes, runs the external ALU and sends the result back LSB first.
// Define UART_ALU_RX_TIMEOUT_EN to abandon partial frames after TIMEOUT_CYCLES idle clocks.
module uart_alu_sequencer #(
   parameter int WIDTH_WORD             = 8,
   parameter int CANT_DATOS_ENTRADA_ALU = 16,
   parameter int CANT_BITS_OPCODE_ALU   = 8,
   parameter int CANT_DATOS_SALIDA_ALU  = 16,
   parameter int TIMEOUT_CYCLES         = 100000
) (
   input  logic                              i_clock,
   input  logic                              i_reset,
   input  logic [WIDTH_WORD-1:0]             i_data_rx,
   input  logic                              i_rx_done,
   input  logic                              i_tx_done,
   input  logic [CANT_DATOS_SALIDA_ALU-1:0]  i_resultado_alu,
   output logic [CANT_DATOS_ENTRADA_ALU-1:0] o_reg_dato_A,
   output logic [CANT_DATOS_ENTRADA_ALU-1:0] o_reg_dato_B,
   output logic [CANT_BITS_OPCODE_ALU-1:0]   o_reg_opcode,
   output logic                              o_tx_start,
   output logic [WIDTH_WORD-1:0]             o_data_tx,
   output logic                              o_busy,
   output logic                              o_error
);

   localparam int NA   = CANT_DATOS_ENTRADA_ALU / WIDTH_WORD;
   localparam int NR   = CANT_DATOS_SALIDA_ALU / WIDTH_WORD;
   localparam int MAXN = (NA > NR) ? NA : NR;
   localparam int CW   = $clog2(MAXN + 1);
   localparam logic [CW-1:0] LAST_A = CW'(NA - 1);
   localparam logic [CW-1:0] LAST_R = CW'(NR - 1);

   typedef enum logic [2:0] {
      IDLE, RX_A, RX_OP, RX_B, EXEC, TX_LOAD, TX_WAIT
   } state_t;

   state_t                           state;
   logic [CW-1:0]                    byte_cnt;
   logic [CANT_DATOS_SALIDA_ALU-1:0] result_reg;

`ifdef UART_ALU_RX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] to_cnt;
`else
   assign o_error = 1'b0;
`endif

   // byte_cnt selects the operand lane while receiving and the result lane while sending
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         state        <= IDLE;
         byte_cnt     <= '0;
         result_reg   <= '0;
         o_reg_dato_A <= '0;
         o_reg_dato_B <= '0;
         o_reg_opcode <= '0;
         o_tx_start   <= 1'b0;
         o_data_tx    <= '0;
         o_busy       <= 1'b0;
`ifdef UART_ALU_RX_TIMEOUT_EN
         o_error      <= 1'b0;
         to_cnt       <= '0;
`endif
      end else begin
         o_tx_start <= 1'b0;
`ifdef UART_ALU_RX_TIMEOUT_EN
         o_error    <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (i_rx_done) begin
                  o_reg_dato_A[0 +: WIDTH_WORD] <= i_data_rx;
                  o_busy   <= 1'b1;
                  byte_cnt <= (NA == 1) ? '0 : CW'(1);
                  state    <= (NA == 1) ? RX_OP : RX_A;
               end
            end
            RX_A: begin
               if (i_rx_done) begin
                  o_reg_dato_A[byte_cnt*WIDTH_WORD +: WIDTH_WORD] <= i_data_rx;
                  if (byte_cnt == LAST_A) begin
                     byte_cnt <= '0;
                     state    <= RX_OP;
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                  end
               end
            end
            RX_OP: begin
               if (i_rx_done) begin
                  o_reg_opcode <= i_data_rx[CANT_BITS_OPCODE_ALU-1:0];
                  byte_cnt     <= '0;
                  state        <= RX_B;
               end
            end
            RX_B: begin
               if (i_rx_done) begin
                  o_reg_dato_B[byte_cnt*WIDTH_WORD +: WIDTH_WORD] <= i_data_rx;
                  if (byte_cnt == LAST_A) begin
                     byte_cnt <= '0;
                     state    <= EXEC;
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                  end
               end
            end
            // operands are complete here, so the combinational ALU result is valid this cycle
            EXEC: begin
               result_reg <= i_resultado_alu;
               byte_cnt   <= '0;
               state      <= TX_LOAD;
            end
            TX_LOAD: begin
               o_data_tx  <= result_reg[byte_cnt*WIDTH_WORD +: WIDTH_WORD];
               o_tx_start <= 1'b1;
               state      <= TX_WAIT;
            end
            TX_WAIT: begin
               if (i_tx_done) begin
                  if (byte_cnt == LAST_R) begin
                     byte_cnt <= '0;
                     o_busy   <= 1'b0;
                     state    <= IDLE;
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                     state    <= TX_LOAD;
                  end
               end
            end
            default: begin
               o_busy <= 1'b0;
               state  <= IDLE;
            end
         endcase
`ifdef UART_ALU_RX_TIMEOUT_EN
         // an expiring frame overrides the receive states, which only move on i_rx_done
         if (state == RX_A || state == RX_OP || state == RX_B) begin
            if (i_rx_done) begin
               to_cnt <= '0;
            end else if (to_cnt == TO_LAST) begin
               to_cnt   <= '0;
               byte_cnt <= '0;
               o_busy   <= 1'b0;
               o_error  <= 1'b1;
               state    <= IDLE;
            end else begin
               to_cnt <= to_cnt + 1'b1;
            end
         end else begin
            to_cnt <= '0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Randomized frame bench for uart_alu_sequencer: an ALU/UART environment plus a frame-level scoreboard of expected result bytes.
`timescale 1ns/1ps
module tb_uart_alu_sequencer;

   logic        i_clock = 1'b0;
   logic        i_reset = 1'b0;
   logic [7:0]  i_data_rx = '0;
   logic        i_rx_done = 1'b0;
   logic        i_tx_done = 1'b0;
   logic [15:0] i_resultado_alu;
   logic [15:0] o_reg_dato_A, o_reg_dato_B;
   logic [7:0]  o_reg_opcode, o_data_tx;
   logic        o_tx_start, o_busy, o_error;

   logic [7:0]  data_rx8 = '0;
   logic        rx_done8 = 1'b0;
   logic        tx_done8 = 1'b0;
   logic [7:0]  res8, a8, b8, op8, data_tx8;
   logic        tx_start8, busy8, error8;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  tx_log[$];
   logic        in_tx = 1'b0;
   logic [7:0]  held = '0;
   int          starts8 = 0;
   logic [7:0]  last_tx8 = '0;

   always #5 i_clock = ~i_clock;

   function automatic logic [15:0] alu(input logic [15:0] a, input logic [7:0] op, input logic [15:0] b);
      case (op)
         8'h20:   return a + b;
         8'h22:   return a - b;
         8'h24:   return a & b;
         8'h25:   return a | b;
         default: return a ^ b;
      endcase
   endfunction

   assign i_resultado_alu = alu(o_reg_dato_A, o_reg_opcode, o_reg_dato_B);
   assign res8 = a8 + b8;

   uart_alu_sequencer #(
      .WIDTH_WORD(8), .CANT_DATOS_ENTRADA_ALU(16), .CANT_BITS_OPCODE_ALU(8),
      .CANT_DATOS_SALIDA_ALU(16), .TIMEOUT_CYCLES(50)
   ) u_dut (
      .i_clock(i_clock), .i_reset(i_reset), .i_data_rx(i_data_rx), .i_rx_done(i_rx_done),
      .i_tx_done(i_tx_done), .i_resultado_alu(i_resultado_alu), .o_reg_dato_A(o_reg_dato_A),
      .o_reg_dato_B(o_reg_dato_B), .o_reg_opcode(o_reg_opcode), .o_tx_start(o_tx_start),
      .o_data_tx(o_data_tx), .o_busy(o_busy), .o_error(o_error)
   );

   uart_alu_sequencer #(
      .WIDTH_WORD(8), .CANT_DATOS_ENTRADA_ALU(8), .CANT_BITS_OPCODE_ALU(8),
      .CANT_DATOS_SALIDA_ALU(8), .TIMEOUT_CYCLES(50)
   ) u_dut8 (
      .i_clock(i_clock), .i_reset(i_reset), .i_data_rx(data_rx8), .i_rx_done(rx_done8),
      .i_tx_done(tx_done8), .i_resultado_alu(res8), .o_reg_dato_A(a8),
      .o_reg_dato_B(b8), .o_reg_opcode(op8), .o_tx_start(tx_start8),
      .o_data_tx(data_tx8), .o_busy(busy8), .o_error(error8)
   );

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Every transmitted byte must match the scoreboard and stay put until the transmitter finishes
   always @(negedge i_clock) begin
      if (!i_reset) begin
         in_tx = 1'b0;
      end else begin
         if (o_tx_start) begin
            tx_log.push_back(o_data_tx);
            if (exp_q.size() == 0) check_output("unexpected_tx_start", {31'd0, o_tx_start}, 32'd0);
            else check_output("tx_byte", {24'd0, o_data_tx}, {24'd0, exp_q.pop_front()});
            held  = o_data_tx;
            in_tx = 1'b1;
         end else if (in_tx) begin
            check_output("tx_hold", {24'd0, o_data_tx}, {24'd0, held});
            if (i_tx_done) in_tx = 1'b0;
         end
         if (tx_start8) begin
            starts8++;
            last_tx8 = data_tx8;
         end
`ifndef UART_ALU_RX_TIMEOUT_EN
         check_output("no_error", {31'd0, o_error}, 32'd0);
         check_output("no_error8", {31'd0, error8}, 32'd0);
`endif
      end
   end

   // Transmitter model: finishes each byte a few cycles after it starts
   initial begin
      forever begin
         @(negedge i_clock);
         if (o_tx_start && i_reset) begin
            repeat ($urandom_range(5, 9)) @(posedge i_clock);
            #1 i_tx_done = 1'b1;
            @(posedge i_clock);
            #1 i_tx_done = 1'b0;
         end
      end
   end

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic apply_stimulus(input logic [7:0] b, input int gap, input bit to8);
      repeat (gap) @(posedge i_clock);
      @(posedge i_clock);
      #1;
      if (to8) begin
         data_rx8 = b;
         rx_done8 = 1'b1;
      end else begin
         i_data_rx = b;
         i_rx_done = 1'b1;
      end
      @(posedge i_clock);
      #1;
      rx_done8  = 1'b0;
      i_rx_done = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 300; i++) begin
         if (!o_busy) break;
         @(negedge i_clock);
      end
      check_output(name, {31'd0, o_busy}, 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_output({tag, "_A"}, {16'd0, o_reg_dato_A}, 32'd0);
      check_output({tag, "_B"}, {16'd0, o_reg_dato_B}, 32'd0);
      check_output({tag, "_op"}, {24'd0, o_reg_opcode}, 32'd0);
      check_output({tag, "_data_tx"}, {24'd0, o_data_tx}, 32'd0);
      check_output({tag, "_tx_start"}, {31'd0, o_tx_start}, 32'd0);
      check_output({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
      check_output({tag, "_error"}, {31'd0, o_error}, 32'd0);
   endtask

   task automatic run_frame(input logic [15:0] a, input logic [7:0] op, input logic [15:0] b,
                            input bit junk, input int maxgap, input int first);
      logic [15:0] r;
      logic [7:0]  bytes [5];
      r = alu(a, op, b);
      bytes[0] = a[7:0];
      bytes[1] = a[15:8];
      bytes[2] = op;
      bytes[3] = b[7:0];
      bytes[4] = b[15:8];
      for (int i = first; i < 5; i++) begin
         if (i == 4) begin
            exp_q.push_back(r[7:0]);
            exp_q.push_back(r[15:8]);
         end
         apply_stimulus(bytes[i], $urandom_range(0, maxgap), 1'b0);
      end
      check_output("busy_after_frame", {31'd0, o_busy}, 32'd1);
      if (junk) begin
         for (int i = 0; i < 20; i++) begin
            if (o_tx_start) break;
            @(negedge i_clock);
         end
         apply_stimulus(8'($urandom), 0, 1'b0);
         apply_stimulus(8'($urandom), 0, 1'b0);
      end
      wait_idle("frame_done");
      check_output("reg_A", {16'd0, o_reg_dato_A}, {16'd0, a});
      check_output("reg_B", {16'd0, o_reg_dato_B}, {16'd0, b});
      check_output("reg_op", {24'd0, o_reg_opcode}, {24'd0, op});
      check_output("tx_queue_empty", exp_q.size(), 32'd0);
   endtask

   initial begin
      logic [7:0] ops [5];
      i_reset = 1'b0;
      repeat (3) @(posedge i_clock);
      #1;
      check_reset_outputs("reset");
      i_reset = 1'b1;

      // Single-byte operands: 5 + 3 comes back as one byte
      apply_stimulus(8'h05, 0, 1'b1);
      apply_stimulus(8'h20, 0, 1'b1);
      apply_stimulus(8'h03, 0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         if (starts8 != 0) break;
         @(negedge i_clock);
      end
      check_output("dut8_tx_byte", {24'd0, last_tx8}, 32'h08);
      @(posedge i_clock);
      #1 tx_done8 = 1'b1;
      @(posedge i_clock);
      #1 tx_done8 = 1'b0;
      repeat (3) @(negedge i_clock);
      check_output("dut8_start_count", starts8, 32'd1);
      check_output("dut8_busy", {31'd0, busy8}, 32'd0);
      check_output("dut8_A", {24'd0, a8}, 32'h05);
      check_output("dut8_op", {24'd0, op8}, 32'h20);
      check_output("dut8_B", {24'd0, b8}, 32'h03);

      // Reference frame with literal expectations
      tx_log.delete();
      run_frame(16'h1234, 8'h20, 16'h0001, 1'b0, 0, 0);
      check_output("lit_tx_count", tx_log.size(), 32'd2);
      if (tx_log.size() == 2) begin
         check_output("lit_tx0", {24'd0, tx_log[0]}, 32'h35);
         check_output("lit_tx1", {24'd0, tx_log[1]}, 32'h12);
      end
      check_output("lit_A", {16'd0, o_reg_dato_A}, 32'h1234);
      check_output("lit_op", {24'd0, o_reg_opcode}, 32'h20);
      check_output("lit_B", {16'd0, o_reg_dato_B}, 32'h0001);

      // Bytes arriving while the result is being sent are dropped
      run_frame(16'hA5C3, 8'h22, 16'h1F00, 1'b1, 1, 0);
      run_frame(16'h0F0F, 8'h24, 16'h00FF, 1'b0, 1, 0);

      // Reset in the middle of a frame
      apply_stimulus(8'h34, 0, 1'b0);
      apply_stimulus(8'h12, 1, 1'b0);
      apply_stimulus(8'h20, 0, 1'b0);
      @(posedge i_clock);
      #1 i_reset = 1'b0;
      exp_q.delete();
      @(posedge i_clock);
      #1;
      check_reset_outputs("midframe_reset");
      i_reset = 1'b1;
      run_frame(16'hBEEF, 8'h22, 16'h1111, 1'b0, 2, 0);

      // Partial frame left hanging
      apply_stimulus(8'h78, 0, 1'b0);
      apply_stimulus(8'h56, 0, 1'b0);
`ifdef UART_ALU_RX_TIMEOUT_EN
      for (int i = 0; i < 80; i++) begin
         @(negedge i_clock);
         if (o_error) break;
      end
      check_output("timeout_error_pulse", {31'd0, o_error}, 32'd1);
      @(negedge i_clock);
      check_output("timeout_error_one_cycle", {31'd0, o_error}, 32'd0);
      check_output("timeout_busy", {31'd0, o_busy}, 32'd0);
      check_output("timeout_keeps_A", {16'd0, o_reg_dato_A}, 32'h5678);
`else
      repeat (60) @(negedge i_clock);
      check_output("stall_busy", {31'd0, o_busy}, 32'd1);
      run_frame(16'h5678, 8'h25, 16'h00F0, 1'b0, 0, 2);
`endif

      // Randomized frames
      ops[0] = 8'h20;
      ops[1] = 8'h22;
      ops[2] = 8'h24;
      ops[3] = 8'h25;
      for (int n = 0; n < 20; n++) begin
         ops[4] = 8'($urandom);
         run_frame(16'($urandom), ops[$urandom_range(0, 4)], 16'($urandom),
                   1'($urandom_range(0, 1)), 3, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
